signed_prod_accum: RTL

- Downstream consumer of the Multi_signed combinational multiplier.
- Takes the 2*WIDTH-bit signed product P, one beat per valid/ready transfer, and accumulates groups of products into a saturating signed sum (dot-product reduction).
- Emits one registered result per group on a valid/ready output port.
- A group ends after LEN accepted beats or at a beat flagged in_last, whichever comes first.

---
 rtl/signed_prod_accum.sv | 105 ++++++++++
 1 files changed

// File: rtl/signed_prod_accum.sv
// Saturating signed dot-product reducer: sums groups of signed products
// and emits one registered result per group over a valid/ready port.
module signed_prod_accum #(
   parameter int WIDTH = 10,
   parameter int ACC_W = 24,
   parameter int LEN   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2*WIDTH-1:0]         in_p,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_sum,
   output logic [$clog2(LEN+1)-1:0]   out_count,
   output logic                       out_ovf
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(LEN + 1);
   localparam logic [CW-1:0]    LAST_CNT = CW'(LEN - 1);
   localparam logic [ACC_W-1:0] SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

   // Returns {ovf, clamped sum}; the ACC_W+1-bit sum can never wrap, so a
   // disagreement between its top two bits means the ACC_W range was left.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [PW-1:0]    p);
      logic [ACC_W:0] wide;
      wide = {a[ACC_W-1], a} + {{(ACC_W+1-PW){p[PW-1]}}, p};
      if (wide[ACC_W] != wide[ACC_W-1]) begin
         if (wide[ACC_W]) begin
            sat_add = {1'b1, SAT_MIN};
         end else begin
            sat_add = {1'b1, SAT_MAX};
         end
      end else begin
         sat_add = {1'b0, wide[ACC_W-1:0]};
      end
   endfunction

   logic [ACC_W-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             ovf_sticky;

   logic             accept;
   logic             closing;
   logic             ovf_now;
   logic [ACC_W-1:0] acc_next;
   logic [CW-1:0]    cnt_next;

   assign in_ready = !out_valid || out_ready;

   // Next-beat arithmetic and group-close decision
   always_comb begin
      accept              = in_valid && in_ready;
      {ovf_now, acc_next} = sat_add(acc, in_p);
      cnt_next            = cnt + CW'(1);
      if (cnt == LAST_CNT) begin
         closing = 1'b1;
      end else begin
         closing = in_last;
      end
   end

   // Running group state: restarts from zero once a group closes
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= {ACC_W{1'b0}};
         cnt        <= {CW{1'b0}};
         ovf_sticky <= 1'b0;
      end else if (accept) begin
         if (closing) begin
            acc        <= {ACC_W{1'b0}};
            cnt        <= {CW{1'b0}};
            ovf_sticky <= 1'b0;
         end else begin
            acc        <= acc_next;
            cnt        <= cnt_next;
            ovf_sticky <= ovf_sticky | ovf_now;
         end
      end
   end

   // Result registers: a closing beat reloads them even while the old
   // result is being consumed, so back-to-back groups see no bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= {ACC_W{1'b0}};
         out_count <= {CW{1'b0}};
         out_ovf   <= 1'b0;
      end else if (accept && closing) begin
         out_valid <= 1'b1;
         out_sum   <= acc_next;
         out_count <= cnt_next;
         out_ovf   <= ovf_sticky | ovf_now;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
